// File: rtl/mem_copy_pkg.sv
// Shared types and default sizes for the block-copy engine.
package mem_copy_pkg;

    localparam int DEFAULT_DBITS = 32;
    localparam int DEFAULT_ABITS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COPY  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    typedef enum logic {
        ASC  = 1'b0,
        DESC = 1'b1
    } dir_t;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Loadable address pointer that steps up or down by one and wraps modulo 2^ABITS.
module mem_copy_addr_gen
    import mem_copy_pkg::*;
#(
    parameter int ABITS = DEFAULT_ABITS
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic [ABITS-1:0] load_addr,
    input  logic             step,
    input  dir_t             dir,
    output logic [ABITS-1:0] ptr
);

    logic [ABITS-1:0] ptr_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr_reg <= '0;
        end else if (load) begin
            ptr_reg <= load_addr;
        end else if (step) begin
            ptr_reg <= (dir == DESC) ? ptr_reg - ABITS'(1) : ptr_reg + ABITS'(1);
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/mem_copy_engine.sv
// memmove-style block copy engine: one word per cycle, direction chosen at accept.
// Optional XOR checksum of written words enabled by MEM_COPY_CHECKSUM_EN.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int DBITS = DEFAULT_DBITS,
    parameter int ABITS = DEFAULT_ABITS
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [ABITS-1:0] SRC,
    input  logic [ABITS-1:0] DST,
    input  logic [ABITS-1:0] LEN,
    output logic             BUSY,
    output logic             DONE,
    output logic [ABITS-1:0] MADDR1,
    output logic [DBITS-1:0] MDIN,
    output logic             MWE,
    output logic [ABITS-1:0] MADDR2,
    input  logic [DBITS-1:0] MDOUT2
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DBITS-1:0] CSUM
`endif
);

    state_t           state_reg, state_next;
    dir_t             dir_reg;
    logic [ABITS-1:0] count_reg;
    logic [DBITS-1:0] data_q_reg;
    logic             valid_q_reg;

    logic             accept;
    logic             noop;
    logic             desc_sel;
    logic [ABITS-1:0] diff;
    logic [ABITS-1:0] len_m1;

    logic             gen_load [2];
    logic [ABITS-1:0] gen_base [2];
    logic             gen_step [2];
    logic [ABITS-1:0] gen_ptr  [2];

    assign accept   = (state_reg == IDLE) && START;
    assign noop     = (LEN == '0) || (DST == SRC);
    assign diff     = DST - SRC;
    assign len_m1   = LEN - ABITS'(1);
    // Destination lies just above the source inside the window: copy from the top down.
    assign desc_sel = (diff != '0) && (diff < LEN);

    assign gen_base[0] = desc_sel ? SRC + len_m1 : SRC;
    assign gen_base[1] = desc_sel ? DST + len_m1 : DST;
    assign gen_step[0] = (state_reg == COPY);
    assign gen_step[1] = MWE;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
            assign gen_load[gi] = accept;
            mem_copy_addr_gen #(
                .ABITS(ABITS)
            ) u_addr_gen (
                .CLK      (CLK),
                .RESET    (RESET),
                .load     (gen_load[gi]),
                .load_addr(gen_base[gi]),
                .step     (gen_step[gi]),
                .dir      (dir_reg),
                .ptr      (gen_ptr[gi])
            );
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        MWE        = 1'b0;
        MADDR1     = '0;
        MDIN       = '0;
        MADDR2     = '0;
        case (state_reg)
            IDLE: begin
                if (START) begin
                    state_next = noop ? FIN : COPY;
                end
            end
            COPY: begin
                BUSY   = 1'b1;
                MADDR2 = gen_ptr[0];
                if (count_reg == ABITS'(1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                BUSY       = 1'b1;
                state_next = FIN;
            end
            FIN: begin
                BUSY       = 1'b1;
                DONE       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (valid_q_reg && (state_reg == COPY || state_reg == DRAIN)) begin
            MWE    = 1'b1;
            MADDR1 = gen_ptr[1];
            MDIN   = data_q_reg;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            dir_reg     <= ASC;
            count_reg   <= '0;
            data_q_reg  <= '0;
            valid_q_reg <= 1'b0;
        end else begin
            if (accept) begin
                dir_reg   <= desc_sel ? DESC : ASC;
                count_reg <= LEN;
            end else if (state_reg == COPY) begin
                count_reg <= count_reg - ABITS'(1);
            end
            valid_q_reg <= (state_reg == COPY);
            if (state_reg == COPY) begin
                data_q_reg <= MDOUT2;
            end
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    logic [DBITS-1:0] csum_reg;

    always_ff @(posedge CLK) begin
        if (RESET || accept) begin
            csum_reg <= '0;
        end else if (MWE) begin
            csum_reg <= csum_reg ^ MDIN;
        end
    end

    assign CSUM = csum_reg;
`else
    // Checksum not built in this configuration.
`endif

endmodule
